shared_mem: RTL and testbench

SHARED_MEM -- requirements
Module: shared_mem

---
 rtl/shared_mem_if.sv | 49 ++++
 rtl/shared_mem.sv | 138 +++++++++++++
 tb/tb_shared_mem.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/shared_mem_if.sv
// cache_mem_if -- request/response bundle between a cache-side requester and
// a memory-side responder.
//
// Handshake: a request transfers on a rising clk edge where mem_req_valid and
// mem_req_ready are both 1. The requester keeps we/addr/write stable while
// valid is high and ready is low. The response side has no backpressure:
// mem_resp_valid is a one-cycle strobe and mem_resp_data is only meaningful
// in the strobe cycle.
//
// Signals:
//   mem_req_valid  requester -> responder  request present
//   mem_req_ready  responder -> requester  responder can accept this cycle
//   mem_req_we     requester -> responder  1 = write, 0 = read
//   mem_req_addr   requester -> responder  word address, ADDR_W bits
//   mem_req_write  requester -> responder  write data, DATA_W bits
//   mem_resp_valid responder -> requester  single-cycle response strobe
//   mem_resp_data  responder -> requester  read data or echoed write data
interface cache_mem_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_write;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;

    modport slave (
        input  mem_req_valid,
        input  mem_req_we,
        input  mem_req_addr,
        input  mem_req_write,
        output mem_req_ready,
        output mem_resp_valid,
        output mem_resp_data
    );

    modport master (
        output mem_req_valid,
        output mem_req_we,
        output mem_req_addr,
        output mem_req_write,
        input  mem_req_ready,
        input  mem_resp_valid,
        input  mem_resp_data
    );
endinterface

// File: rtl/shared_mem.sv
// shared_mem -- single-ported word memory with a fixed request-to-response
// latency and at most one transaction in flight.
//
// Ports:
//   clk      clock, all state updates on the rising edge
//   resetN   asynchronous, active-low reset (storage is not cleared)
//   mem_if   cache_mem_if.slave request/response bundle
//   mem_err  sticky out-of-range flag (0 unless SHARED_MEM_ADDR_CHECK_EN)
//
// Optional feature: define SHARED_MEM_ADDR_CHECK_EN to flag addresses >= DEPTH.
// Such requests keep normal timing, writes are dropped, reads return
// {DATA_W/4{4'hE}}, and mem_err sets until reset. Without the macro the
// address simply wraps modulo DEPTH.
//
// Timing: accept on edge N (IDLE and valid), WAIT for LATENCY edges, the access
// commits on edge N+LATENCY and the response strobe occupies the following
// cycle (RESP). RESP always returns to IDLE, so back-to-back requests are
// accepted every LATENCY+2 cycles.
module shared_mem #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic       clk,
    input  logic       resetN,
    cache_mem_if.slave mem_if,
    output logic       mem_err
);
    localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]        LAT_M1   = 4'(LATENCY - 1);
    localparam logic [DATA_W-1:0] ERR_WORD = {DATA_W/4{4'hE}};

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic              ready_q;
    logic              resp_valid_q;
    logic [DATA_W-1:0] resp_data_q;
    logic              we_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic              oor_q;
    logic              commit;
    logic              wr_en;
    logic [IDX_W-1:0]  req_idx;

    // Storage has no reset; it relies on the power-up zero state of the
    // target (memory init file / simulator zero-initialisation).
    logic [DATA_W-1:0] mem [DEPTH];

    assign req_idx = mem_if.mem_req_addr[IDX_W-1:0];
    assign commit  = (state == WAIT) && (cnt == 4'd0);
    // An out-of-range write completes but never touches storage.
    assign wr_en   = commit && we_q && !oor_q;

`ifdef SHARED_MEM_ADDR_CHECK_EN
    logic req_oor;
    logic err_q;
    // Widen by one bit so DEPTH == 2**ADDR_W still compares correctly.
    assign req_oor = ({1'b0, mem_if.mem_req_addr} >= (ADDR_W + 1)'(DEPTH));
    assign mem_err = err_q;
`else
    logic unused_addr;
    assign oor_q       = 1'b0;
    assign mem_err     = 1'b0;
    assign unused_addr = ^mem_if.mem_req_addr;
`endif

    assign mem_if.mem_req_ready  = ready_q;
    assign mem_if.mem_resp_valid = resp_valid_q;
    assign mem_if.mem_resp_data  = resp_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx_q] <= wdata_q;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            we_q         <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
`ifdef SHARED_MEM_ADDR_CHECK_EN
            oor_q        <= 1'b0;
            err_q        <= 1'b0;
`endif
        end else begin
            resp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_if.mem_req_valid) begin
                        state   <= WAIT;
                        ready_q <= 1'b0;
                        cnt     <= LAT_M1;
                        we_q    <= mem_if.mem_req_we;
                        idx_q   <= req_idx;
                        wdata_q <= mem_if.mem_req_write;
`ifdef SHARED_MEM_ADDR_CHECK_EN
                        oor_q   <= req_oor;
`endif
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state        <= RESP;
                        resp_valid_q <= 1'b1;
                        // Writes echo the captured data, even when dropped.
                        resp_data_q  <= we_q  ? wdata_q :
                                        oor_q ? ERR_WORD : mem[idx_q];
`ifdef SHARED_MEM_ADDR_CHECK_EN
                        if (oor_q) begin
                            err_q <= 1'b1;
                        end
`endif
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shared_mem.sv
// tb_shared_mem -- self-checking bench for shared_mem.
// Table-driven directed vectors, hand-written multi-cycle sequences (reset,
// held valid, reset mid-flight) and randomized traffic against a word-level
// reference model held in an associative array.
`timescale 1ns/1ps
module tb_shared_mem;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 32;
    localparam int DEPTH   = 1024;
    localparam int LATENCY = 2;

    logic clk    = 1'b0;
    logic resetN = 1'b0;
    logic mem_err;

    cache_mem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

    shared_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LATENCY(LATENCY)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .mem_if (mem_if),
        .mem_err(mem_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [DATA_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] model_mem [int];
    logic              model_err = 1'b0;

    function automatic logic [DATA_W-1:0] model_access(input logic we, input logic [ADDR_W-1:0] addr,
                                                      input logic [DATA_W-1:0] wd);
        int k;
        bit oor;
        k   = int'(addr) % DEPTH;
        oor = 1'b0;
`ifdef SHARED_MEM_ADDR_CHECK_EN
        oor = (int'(addr) >= DEPTH);
        if (oor) model_err = 1'b1;
`endif
        if (we) begin
            if (!oor) model_mem[k] = wd;
            return wd;
        end
        if (oor) return {DATA_W/4{4'hE}};
        return model_mem.exists(k) ? model_mem[k] : '0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic apply_reset(input int cycles);
        @(negedge clk);
        resetN = 1'b0;
        model_err = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            check("rst_resp_valid", mem_if.mem_resp_valid, 0);
            check("rst_resp_data", mem_if.mem_resp_data, 0);
            check("rst_mem_err", mem_err, 0);
        end
        resetN = 1'b1;
        @(negedge clk);
        check("post_rst_ready", mem_if.mem_req_ready, 1);
        check("post_rst_resp_valid", mem_if.mem_resp_valid, 0);
        check("post_rst_mem_err", mem_err, 0);
    endtask

    // Starts and ends on a negedge with the block idle.
    task automatic txn(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd,
                       input logic [DATA_W-1:0] exp, input logic exp_err);
        int  k;
        bit  got;
        check("ready_before_req", mem_if.mem_req_ready, 1);
        mem_if.mem_req_valid = 1'b1;
        mem_if.mem_req_we    = we;
        mem_if.mem_req_addr  = addr;
        mem_if.mem_req_write = wd;
        exp_q.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        // Garbage on the request lines while busy must be ignored.
        mem_if.mem_req_valid = 1'b0;
        mem_if.mem_req_we    = ~we;
        mem_if.mem_req_addr  = 16'($urandom);
        mem_if.mem_req_write = $urandom;
        got = 1'b0;
        for (k = 0; k <= 20; k++) begin
            if (mem_if.mem_resp_valid) begin
                got = 1'b1;
                break;
            end
            check("ready_low_wait", mem_if.mem_req_ready, 0);
            @(negedge clk);
        end
        check("resp_seen", got, 1);
        if (got) begin
            logic [DATA_W-1:0] e;
            e = exp_q.pop_front();
            check("resp_latency", k, LATENCY);
            check("resp_data", mem_if.mem_resp_data, e);
            check("ready_low_resp", mem_if.mem_req_ready, 0);
            check("mem_err", mem_err, exp_err);
            @(negedge clk);
            check("resp_one_cycle", mem_if.mem_resp_valid, 0);
            check("resp_data_hold", mem_if.mem_resp_data, e);
            check("ready_back", mem_if.mem_req_ready, 1);
        end else begin
            void'(exp_q.pop_front());
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wd;
        logic [DATA_W-1:0] exp;
        logic              exp_err;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [DATA_W-1:0] mexp;
        int acc_cnt, resp_cnt, last_acc, resp_bad;
        bit seen;

        mem_if.mem_req_valid = 1'b0;
        mem_if.mem_req_we    = 1'b0;
        mem_if.mem_req_addr  = '0;
        mem_if.mem_req_write = '0;

        vecs[0] = '{1'b1, 16'h0010, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0};
        vecs[1] = '{1'b0, 16'h0010, 32'h0,        32'hCAFEF00D, 1'b0};
        vecs[2] = '{1'b0, 16'h0005, 32'h0,        32'h00000000, 1'b0};
        vecs[3] = '{1'b1, 16'h03FF, 32'hA5A55A5A, 32'hA5A55A5A, 1'b0};
        vecs[4] = '{1'b0, 16'h03FF, 32'h0,        32'hA5A55A5A, 1'b0};
        vecs[5] = '{1'b1, 16'h0010, 32'h11112222, 32'h11112222, 1'b0};
        vecs[6] = '{1'b0, 16'h0010, 32'h0,        32'h11112222, 1'b0};
`ifdef SHARED_MEM_ADDR_CHECK_EN
        vecs[7] = '{1'b1, 16'h0400, 32'h00000001, 32'h00000001, 1'b1};
        vecs[8] = '{1'b0, 16'h0000, 32'h0,        32'h00000000, 1'b1};
        vecs[9] = '{1'b0, 16'h0400, 32'h0,        32'hEEEEEEEE, 1'b1};
`else
        vecs[7] = '{1'b1, 16'h0400, 32'h00000001, 32'h00000001, 1'b0};
        vecs[8] = '{1'b0, 16'h0000, 32'h0,        32'h00000001, 1'b0};
        vecs[9] = '{1'b0, 16'h0400, 32'h0,        32'h00000001, 1'b0};
`endif

        // Reset then idle.
        apply_reset(3);

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            void'(model_access(vecs[i].we, vecs[i].addr, vecs[i].wd));
            txn(vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].exp, vecs[i].exp_err);
        end

        // Reset mid-flight: the write to 0x20 must vanish.
        check("mid_ready", mem_if.mem_req_ready, 1);
        mem_if.mem_req_valid = 1'b1;
        mem_if.mem_req_we    = 1'b1;
        mem_if.mem_req_addr  = 16'h0020;
        mem_if.mem_req_write = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        mem_if.mem_req_valid = 1'b0;
        check("mid_in_wait", mem_if.mem_req_ready, 0);
        resetN    = 1'b0;
        model_err = 1'b0;
        #1;
        check("mid_rst_resp_data", mem_if.mem_resp_data, 0);
        check("mid_rst_mem_err", mem_err, 0);
        repeat (2) begin
            @(negedge clk);
            check("mid_rst_no_resp", mem_if.mem_resp_valid, 0);
        end
        resetN = 1'b1;
        seen = 1'b0;
        repeat (LATENCY + 3) begin
            @(negedge clk);
            if (mem_if.mem_resp_valid) seen = 1'b1;
        end
        check("mid_no_late_resp", seen, 0);
        txn(1'b0, 16'h0020, 32'h0, 32'h0, 1'b0);

        // Held valid: reads of 0x0001 for 10 cycles.
        mexp = model_access(1'b0, 16'h0001, 32'h0);
        mem_if.mem_req_valid = 1'b1;
        mem_if.mem_req_we    = 1'b0;
        mem_if.mem_req_addr  = 16'h0001;
        acc_cnt  = 0;
        resp_cnt = 0;
        resp_bad = 0;
        last_acc = -1;
        for (int c = 0; c < 10 + LATENCY + 2; c++) begin
            if (c == 10) mem_if.mem_req_valid = 1'b0;
            if (c < 10 && mem_if.mem_req_ready) begin
                if (last_acc >= 0) check("held_gap", c - last_acc, LATENCY + 2);
                last_acc = c;
                acc_cnt++;
            end
            if (mem_if.mem_resp_valid) begin
                resp_cnt++;
                if (mem_if.mem_resp_data !== mexp) resp_bad++;
            end
            @(negedge clk);
        end
        check("held_accepts", acc_cnt, (10 + LATENCY + 1) / (LATENCY + 2));
        check("held_resps", resp_cnt, acc_cnt);
        check("held_resp_data_bad", resp_bad, 0);
        check("held_idle_after", mem_if.mem_req_ready, 1);

        // Randomized traffic against the model (addresses may exceed DEPTH).
        for (int i = 0; i < 60; i++) begin
            logic              we;
            logic [ADDR_W-1:0] addr;
            logic [DATA_W-1:0] wd;
            logic [DATA_W-1:0] e;
            we   = 1'($urandom_range(0, 1));
            addr = 16'($urandom_range(0, 2 * DEPTH - 1));
            if ($urandom_range(0, 3) == 0) addr = 16'($urandom_range(0, 7));
            wd   = $urandom;
            e    = model_access(we, addr, wd);
            txn(we, addr, wd, e, model_err);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
